run_detect_sched: RTL
=====================

# run_detect_sched

Round-robin scheduler that shares one run-length detection datapath among NCH serial bit-stream requesters. Each cycle it grants one requesting channel and feeds that channel's bit through the shared run counter, using a saved per-channel context. It flags when the channel has seen RUN_LEN consecutive identical bits, either all ones or all zeros. It sits between the serial front-ends and the event logic, replacing one detector FSM per stream.

## Interface
- NCH, 4: number of requesting channels; legal values are 2..8.
- RUN_LEN, 3: number of consecutive equal bits that counts as a detection; legal values are 2..15.
- CNT_W, 8: width of each per-channel event counter. Used only under `DET_EVENT_CNT_EN`.
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of all contexts, the arbiter pointer and the counters.
- req  input  NCH  per-channel request; bit i high means bit_in[i] is valid this cycle.
- bit_in  input  NCH  per-channel serial data bit.
- gnt  output  NCH  one-hot grant, combinational from req, ptr and clr. The granted bit is consumed on this cycle's rising edge.
- det_valid  output  1  registered detection strobe.
- det_ch  output  $clog2(NCH)  channel index of the detection.
- det_pol  output  1  polarity of the detected run: 1 = ones, 0 = zeros.
- evt_cnt  output  NCH*CNT_W  per-channel detection counts; channel i occupies bits [i*CNT_W +: CNT_W]. Present only under `DET_EVENT_CNT_EN`.

## Operation
- **Arbitration:** round-robin with a pointer ptr.
  - Search starts at ptr and wraps modulo NCH.
  - The first channel with req high gets gnt.
  - After a grant, ptr becomes (granted index + 1) mod NCH.
  - If no channel requests, gnt = 0 and ptr holds.
- **Per-channel context:** seen (1b), last (1b), run (4b).
- **Update on the granted channel:**
  - If seen = 0 or bit_in ≠ last, then run ← 1.
  - Otherwise run ← min(run + 1, RUN_LEN); run saturates at RUN_LEN.
  - last ← bit_in and seen ← 1.
  - All other channels' contexts hold.
- **Detection:**
  - If the updated run equals RUN_LEN, the next cycle shows det_valid = 1, det_ch = granted index and det_pol = bit_in.
  - Detection is overlapping: a continuing run fires on every further granted equal bit.
  - A detection needs RUN_LEN grants of that channel. Interleaved grants to other channels do not break a run.
- **Event counters:** the counter for the detecting channel increments and saturates at 2^CNT_W − 1.
- **clr behaviour:**
  - clr forces gnt = 0.
  - On the next edge: all contexts return to seen = 0, run = 0, last = 0; ptr = 0; counters = 0; det_valid = 0.
- **Reset:** reset_n low clears the same state as clr, asynchronously. Outputs after reset: gnt = 0 (combinationally, while req = 0), det_valid = 0, det_ch = 0, det_pol = 0, evt_cnt = 0.
- **Reset mid-run:** no partial run survives; detection restarts from seen = 0.

## Timing
- Grant to detection is 1 cycle: det_* is registered off the edge that consumes the bit.
- Throughput is one bit per cycle aggregate. With all channels requesting, each channel gets 1 grant every NCH cycles.
- det_valid is a single-cycle strobe per detection. It can be high in consecutive cycles, for the same or different channels.
- When det_valid = 0, det_ch and det_pol hold their last values.
- A channel whose req drops simply misses grants; there is no timeout.

## Configuration
- `DET_EVENT_CNT_EN` defined:
  - The per-channel saturating counters and the evt_cnt port are built.
  - clr and reset zero the counters.
- `DET_EVENT_CNT_EN` not defined:
  - No counters are built and the evt_cnt port is absent.
  - All other behaviour is identical.

## Structure
- Package run_detect_pkg holds:
  - the polarity constants POL_ZEROS = 1'b0 and POL_ONES = 1'b1;
  - the context struct type (seen, last, run);
  - the RUN_W = 4 constant.
- Sub-module rr_arbiter (parameter N):
  - inputs: req, ptr;
  - outputs: one-hot gnt and the encoded index;
  - purely combinational.
- The top level holds ptr, the context array, the detect registers and the counters.

## Test plan
- **Single channel, ones run:** reset, then req = 0001 with ch0 bits 1,1,1,1. Expect det_valid on the cycles after the 3rd and 4th grant, with det_ch = 0 and det_pol = 1.
- **Interleaved channels:** req = 0011 constant; ch0 bits 0,0,0 and ch1 bits 1,0,1.
  - Grants alternate 0001, 0010, starting with ch0.
  - Expect exactly one detection: ch0, det_pol = 0, one cycle after ch0's 3rd grant.
  - ch1 gives no detection.
- **Round-robin fairness:** req = 1111 for 8 cycles. Expect gnt sequence 0001, 0010, 0100, 1000, 0001, …
- **Polarity break:** ch2 bits 1,1,0,0,0. Expect a single detection with det_pol = 0, after the 5th bit.
- **Clear and reset mid-run:**
  - ch0 bits 1,1, then clr for 1 cycle, then bit 1. Expect no detection and gnt = 0 during clr.
  - Repeat the same stimulus with reset_n pulsed low instead of clr. Outputs go to their reset values immediately.
- **Counter saturation (`DET_EVENT_CNT_EN`, CNT_W = 2):** ch1 sends a run of 10 ones. Expect evt_cnt[ch1] to go 1, 2, 3, then hold at 3.

Source files
------------

// File: rtl/run_detect_sched_pkg.sv
// Shared types and constants for the run-length detection scheduler.
//   POL_ZEROS / POL_ONES : polarity encoding of det_pol
//   RUN_W                : width of the per-channel run counter
//   ctx_t                : saved per-channel detection context
package run_detect_pkg;

  localparam int unsigned RUN_W = 4;

  localparam logic POL_ZEROS = 1'b0;
  localparam logic POL_ONES  = 1'b1;

  typedef struct packed {
    logic             seen;
    logic             last;
    logic [RUN_W-1:0] run;
  } ctx_t;

endpackage

// File: rtl/run_detect_sched_if.sv
// Bus between the serial front-ends (master) and the scheduler (slave).
//   clr       : synchronous clear of all scheduler state
//   req       : per-channel request, bit_in[i] valid when req[i]
//   bit_in    : per-channel serial bit
//   gnt       : one-hot grant (combinational)
//   det_valid : registered detection strobe
//   det_ch    : detecting channel index
//   det_pol   : detected run polarity (1 = ones)
//   evt_cnt   : per-channel detection counts (only with DET_EVENT_CNT_EN)
interface run_detect_sched_if #(
  parameter int unsigned NCH = 4
`ifdef DET_EVENT_CNT_EN
  , parameter int unsigned CNT_W = 8
`endif
);
  localparam int unsigned CH_W = $clog2(NCH);

  logic            clr;
  logic [NCH-1:0]  req;
  logic [NCH-1:0]  bit_in;
  logic [NCH-1:0]  gnt;
  logic            det_valid;
  logic [CH_W-1:0] det_ch;
  logic            det_pol;
`ifdef DET_EVENT_CNT_EN
  logic [NCH*CNT_W-1:0] evt_cnt;

  modport master (output clr, req, bit_in,
                  input  gnt, det_valid, det_ch, det_pol, evt_cnt);
  modport slave  (input  clr, req, bit_in,
                  output gnt, det_valid, det_ch, det_pol, evt_cnt);
`else
  modport master (output clr, req, bit_in,
                  input  gnt, det_valid, det_ch, det_pol);
  modport slave  (input  clr, req, bit_in,
                  output gnt, det_valid, det_ch, det_pol);
`endif

endinterface

// File: rtl/run_detect_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr,
// wrapping modulo N.
//   req : request vector
//   ptr : search start index
//   gnt : one-hot grant (zero when nothing requests)
//   idx : encoded index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  localparam int unsigned PW = $clog2(N);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    logic          found;
    logic [PW-1:0] pos;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = PW'((32'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/run_detect_sched.sv
// Round-robin scheduler sharing one run-length detector among NCH serial
// channels. Each cycle one requesting channel is granted and its bit is
// folded into that channel's saved context; RUN_LEN equal bits in a row
// (ones or zeros) raise a one-cycle det_valid strobe on the next cycle.
// Optional per-channel saturating event counters: define DET_EVENT_CNT_EN.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : run_detect_sched_if slave (clr, req, bit_in, gnt, det_*, evt_cnt)
module run_detect_sched
  import run_detect_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned RUN_LEN = 3
`ifdef DET_EVENT_CNT_EN
  , parameter int unsigned CNT_W = 8
`endif
) (
  input logic               clk,
  input logic               reset_n,
  run_detect_sched_if.slave bus
);
  localparam int unsigned     CH_W    = $clog2(NCH);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NCH - 1);

  logic [CH_W-1:0]  ptr;
  ctx_t             ctx [NCH];
  logic [NCH-1:0]   arb_req;
  logic [NCH-1:0]   arb_gnt;
  logic [CH_W-1:0]  gidx;
  logic             granted;
  logic             bit_g;
  ctx_t             cur;
  logic [RUN_W-1:0] run_nxt;
  logic             hit;
  logic [CH_W-1:0]  ptr_nxt;
  logic             det_valid_q;
  logic [CH_W-1:0]  det_ch_q;
  logic             det_pol_q;

  // clr suppresses all grants so nothing is consumed on the clearing edge.
  assign arb_req = bus.clr ? '0 : bus.req;

  rr_arbiter #(.N(NCH)) u_arb (
    .req (arb_req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (gidx)
  );

  assign bus.gnt = arb_gnt;
  assign granted = |arb_gnt;
  assign bit_g   = bus.bit_in[gidx];
  assign cur     = ctx[gidx];
  assign ptr_nxt = (gidx == LAST_CH) ? '0 : gidx + CH_W'(1);

  // Run update for the granted channel; saturating keeps overlapping
  // detections firing on every further equal bit.
  always_comb begin
    run_nxt = RUN_W'(1);
    if (cur.seen && (bit_g == cur.last)) begin
      run_nxt = (cur.run >= RUN_MAX) ? RUN_MAX : cur.run + RUN_W'(1);
    end
    hit = granted && (run_nxt == RUN_MAX);
  end

  // Arbiter pointer and per-channel contexts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      ctx <= '{default: '0};
    end else if (bus.clr) begin
      ptr <= '0;
      ctx <= '{default: '0};
    end else if (granted) begin
      ptr       <= ptr_nxt;
      ctx[gidx] <= '{seen: 1'b1, last: bit_g, run: run_nxt};
    end
  end

  // Detection outputs; channel and polarity hold between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      det_pol_q   <= POL_ZEROS;
    end else if (bus.clr) begin
      det_valid_q <= 1'b0;
    end else begin
      det_valid_q <= hit;
      if (hit) begin
        det_ch_q  <= gidx;
        det_pol_q <= bit_g ? POL_ONES : POL_ZEROS;
      end
    end
  end

  assign bus.det_valid = det_valid_q;
  assign bus.det_ch    = det_ch_q;
  assign bus.det_pol   = det_pol_q;

`ifdef DET_EVENT_CNT_EN
  logic [CNT_W-1:0] cnt [NCH];

  // Saturating per-channel detection counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '{default: '0};
    end else if (bus.clr) begin
      cnt <= '{default: '0};
    end else if (hit && (cnt[gidx] != '1)) begin
      cnt[gidx] <= cnt[gidx] + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_evt
    assign bus.evt_cnt[gi*CNT_W +: CNT_W] = cnt[gi];
  end
`endif

endmodule
